spi_cmd_rx: RTL and testbench

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

---
 rtl/draw_pkg.sv | 35 +++
 rtl/spi_sync.sv | 89 ++++++++
 rtl/spi_cmd_rx.sv | 175 +++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the SPI drawing-command receiver.
//   FRAME_BITS      : length of one command frame on the SPI bus
//   BITCNT_MAX      : saturation value of the frame bit counter
//   BITCNT_W        : width of the frame bit counter
//   H_ACTIVE        : number of visible columns; x must be below this
//   V_ACTIVE        : number of visible rows; y must be below this
//   *_POS/_MSB/_LSB : field positions inside a 24-bit frame
//   rx_state_t      : receiver FSM states
// -----------------------------------------------------------------------------
package draw_pkg;

    localparam int FRAME_BITS = 24;
    localparam int BITCNT_MAX = 25;
    localparam int BITCNT_W   = 5;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;

    localparam int BRUSH_POS = 23;
    localparam int COLOR_MSB = 22;
    localparam int COLOR_LSB = 20;
    localparam int X_MSB     = 19;
    localparam int X_LSB     = 10;
    localparam int Y_MSB     = 9;
    localparam int Y_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Brings the asynchronous SPI pins into the clk domain and produces
// single-cycle edge pulses on the synchronized values.
//   clk      in   system clock, all logic on its rising edge
//   reset    in   synchronous active-low reset
//   sck      in   raw SPI clock
//   sdi      in   raw SPI data
//   cs       in   raw active-low chip select
//   sdi_s    out  synchronized sdi
//   cs_s     out  synchronized, glitch-filtered cs
//   sck_rise out  one-cycle pulse on a synchronized sck rising edge
//   sck_fall out  one-cycle pulse on a synchronized sck falling edge
//   cs_rise  out  one-cycle pulse on a filtered cs rising edge
//   cs_fall  out  one-cycle pulse on a filtered cs falling edge
// -----------------------------------------------------------------------------
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic sdi,
    input  logic cs,
    output logic sdi_s,
    output logic cs_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] sck_chain;
    logic [SYNC_STAGES-1:0] sdi_chain;
    logic [SYNC_STAGES-1:0] cs_chain;
    logic                   sck_prev;
    logic                   cs_filt;
    logic                   cs_armed;
    logic [1:0]             fill_cnt;
    logic                   fill_done;
    logic                   cs_all_high;
    logic                   cs_all_low;

    // cs only changes its filtered value once every stage agrees, so a pulse
    // shorter than SYNC_STAGES cycles never reaches the filtered output.
    assign cs_all_high = &cs_chain;
    assign cs_all_low  = ~|cs_chain;

    // The chain holds reset values until SYNC_STAGES real samples have passed.
    assign fill_done = (fill_cnt == 2'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_chain <= '0;
            sdi_chain <= '0;
            cs_chain  <= '1;
            sck_prev  <= 1'b0;
            cs_filt   <= 1'b1;
            cs_armed  <= 1'b0;
            fill_cnt  <= '0;
        end else begin
            sck_chain <= {sck_chain[SYNC_STAGES-2:0], sck};
            sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], sdi};
            cs_chain  <= {cs_chain[SYNC_STAGES-2:0], cs};
            sck_prev  <= sck_chain[SYNC_STAGES-1];
            if (cs_all_high) begin
                cs_filt <= 1'b1;
            end else if (cs_all_low) begin
                cs_filt <= 1'b0;
            end
            if (!fill_done) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            // A falling edge only counts once cs has really been seen high
            // after reset; cs held low through reset must not open a frame.
            if (fill_done && cs_all_high) begin
                cs_armed <= 1'b1;
            end
        end
    end

    assign sdi_s    = sdi_chain[SYNC_STAGES-1];
    assign cs_s     = cs_filt;
    assign sck_rise =  sck_chain[SYNC_STAGES-1] & ~sck_prev;
    assign sck_fall = ~sck_chain[SYNC_STAGES-1] &  sck_prev;
    assign cs_rise  = cs_all_high & ~cs_filt;
    assign cs_fall  = cs_all_low  &  cs_filt & cs_armed;

endmodule

// File: rtl/spi_cmd_rx.sv
// -----------------------------------------------------------------------------
// spi_cmd_rx
// Receives 24-bit drawing commands from an MCU over SPI (mode 0, MSB first),
// validates them and publishes the accepted command. While a frame is being
// received the MCU is sent a status word {accepted, rejected, 8'h00}.
//   clk      in   system pixel clock
//   reset    in   synchronous active-low reset
//   sck      in   SPI clock (asynchronous, at most clk/4)
//   sdi      in   SPI data in, MSB first
//   cs       in   active-low chip select framing one command
//   sdo      out  SPI status data, MSB first, 0 outside a frame
//   brush    out  brush flag of the last accepted command
//   newColor out  color code of the last accepted command
//   x        out  column of the last accepted command
//   y        out  row of the last accepted command
//   ready    out  one-cycle pulse when brush/newColor/x/y were updated
// -----------------------------------------------------------------------------
module spi_cmd_rx
    import draw_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs,
    output logic       sdo,
    output logic       brush,
    output logic [2:0] newColor,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       ready
);

    rx_state_t               state;
    rx_state_t               next_state;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [FRAME_BITS-1:0]   tx_reg;
    logic [BITCNT_W-1:0]     bit_cnt;
    logic [7:0]              accepted_cnt;
    logic [7:0]              rejected_cnt;
    logic                    fall_pending;
    logic                    start_frame;
    logic                    sck_rise_ok;
    logic                    sck_fall_ok;
    logic                    frame_ok;
    logic [9:0]              frame_x;
    logic [9:0]              frame_y;

    logic                    sdi_s;
    logic                    cs_s;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    cs_rise;
    logic                    cs_fall;

    spi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .sdi      (sdi),
        .cs       (cs),
        .sdi_s    (sdi_s),
        .cs_s     (cs_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A cs fall that lands in CHECK is remembered in fall_pending and taken
    // from IDLE as long as cs is still low.
    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall || (fall_pending && !cs_s)) begin
                    next_state  = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A cs rise wins over an sck edge seen in the same cycle.
    assign sck_rise_ok = (state == SHIFT) && sck_rise && !cs_rise;
    assign sck_fall_ok = (state == SHIFT) && sck_fall && !cs_rise;

    assign frame_x  = shift_reg[X_MSB:X_LSB];
    assign frame_y  = shift_reg[Y_MSB:Y_LSB];
    assign frame_ok = (bit_cnt == BITCNT_W'(FRAME_BITS)) &&
                      (frame_x < H_ACTIVE) && (frame_y < V_ACTIVE);

    assign sdo = (state == SHIFT) ? tx_reg[FRAME_BITS-1] : 1'b0;

    // Datapath: shift-in, status shift-out, validation and result registers.
    // Results and ready are registered in CHECK, so they appear the cycle after.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_reg    <= '0;
            tx_reg       <= '0;
            bit_cnt      <= '0;
            accepted_cnt <= '0;
            rejected_cnt <= '0;
            fall_pending <= 1'b0;
            brush        <= 1'b0;
            newColor     <= '0;
            x            <= '0;
            y            <= '0;
            ready        <= 1'b0;
        end else begin
            ready <= 1'b0;

            if (start_frame) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                tx_reg    <= {accepted_cnt, rejected_cnt, 8'h00};
            end

            if (sck_rise_ok) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s};
                if (bit_cnt != BITCNT_W'(BITCNT_MAX)) begin
                    bit_cnt <= bit_cnt + BITCNT_W'(1);
                end
            end

            if (sck_fall_ok) begin
                tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
            end

            if (state == CHECK) begin
                if (frame_ok) begin
                    brush        <= shift_reg[BRUSH_POS];
                    newColor     <= shift_reg[COLOR_MSB:COLOR_LSB];
                    x            <= frame_x;
                    y            <= frame_y;
                    ready        <= 1'b1;
                    accepted_cnt <= accepted_cnt + 8'd1;
                end else begin
                    rejected_cnt <= rejected_cnt + 8'd1;
                end
            end

            if ((state == CHECK) && cs_fall) begin
                fall_pending <= 1'b1;
            end else if (state == IDLE) begin
                fall_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_rx
// Drives SPI command frames into spi_cmd_rx and checks the published commands,
// the status word returned on sdo, and reset behaviour against a reference
// model kept here in terms of frames, counters and the last accepted command.
// -----------------------------------------------------------------------------
module tb_spi_cmd_rx;

    typedef struct packed {
        logic       brush;
        logic [2:0] color;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       sdi;
    logic       cs;
    logic       sdo;
    logic       brush;
    logic [2:0] newColor;
    logic [9:0] x;
    logic [9:0] y;
    logic       ready;

    int         checks = 0;
    int         errors = 0;
    int         ready_count = 0;
    int         exp_ready_count = 0;
    logic       prev_ready = 1'b0;

    exp_t       exp_q[$];
    logic [7:0] m_acc = 8'd0;
    logic [7:0] m_rej = 8'd0;
    exp_t       m_hold = '0;
    logic [24:0] last_cap = '0;

    always #5 clk = ~clk;

    spi_cmd_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .sdi      (sdi),
        .cs       (cs),
        .sdo      (sdo),
        .brush    (brush),
        .newColor (newColor),
        .x        (x),
        .y        (y),
        .ready    (ready)
    );

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_output(input string name);
        check_val({name, "_brush"}, 32'(brush),    32'(m_hold.brush));
        check_val({name, "_color"}, 32'(newColor), 32'(m_hold.color));
        check_val({name, "_x"},     32'(x),        32'(m_hold.x));
        check_val({name, "_y"},     32'(y),        32'(m_hold.y));
    endtask

    task automatic model_reset();
        m_acc  = 8'd0;
        m_rej  = 8'd0;
        m_hold = '0;
        exp_q.delete();
    endtask

    function automatic logic [24:0] rand_valid();
        exp_t f;
        f.brush = 1'($urandom);
        f.color = 3'($urandom);
        f.x     = 10'($urandom_range(639, 0));
        f.y     = 10'($urandom_range(479, 0));
        return {1'b0, f};
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding accept.
    always @(negedge clk) begin
        if (reset) begin
            if (ready) begin
                exp_t e;
                ready_count++;
                check_val("ready_width", 32'(prev_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL ready_unexpected actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    check_val("mon_brush", 32'(brush),    32'(e.brush));
                    check_val("mon_color", 32'(newColor), 32'(e.color));
                    check_val("mon_x",     32'(x),        32'(e.x));
                    check_val("mon_y",     32'(y),        32'(e.y));
                end
            end
            prev_ready = ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    // Sends nbits of data (data[nbits-1] first) with an sck half period of
    // 'half' clk cycles, capturing sdo just before every sck rise.
    task automatic apply_stimulus(input logic [24:0] data, input int nbits,
                                  input int half, input bit chk_sdo);
        logic [23:0] exp_tx;
        logic [24:0] cap;
        logic [24:0] exp_cap;
        logic [24:0] mask;
        exp_t        f;
        bit          accept;

        exp_tx = {m_acc, m_rej, 8'h00};
        f      = exp_t'(data[23:0]);
        accept = (nbits == 24) && (f.x < 10'd640) && (f.y < 10'd480);
        if (accept) begin
            exp_q.push_back(f);
            m_hold = f;
            m_acc  = m_acc + 8'd1;
            exp_ready_count++;
        end else begin
            m_rej = m_rej + 8'd1;
        end

        cap = '0;
        cs  = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdi = data[nbits-1-i];
            repeat (half) @(negedge clk);
            cap[24-i] = sdo;
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
        repeat (half) @(negedge clk);
        cs  = 1'b1;
        sdi = 1'b0;
        repeat (12) @(negedge clk);
        last_cap = cap;

        if (chk_sdo) begin
            exp_cap = {exp_tx, 1'b0};
            mask    = ~(25'h1ffffff >> nbits);
            check_val("sdo_bits", 32'(cap & mask), 32'(exp_cap & mask));
        end
        check_val("ready_pending", 32'(exp_q.size()), 32'd0);
        check_output("hold");
    endtask

    // Reset lands at bit 12 of a valid frame with cs still low; sck keeps
    // toggling under the low cs, which must not open a frame.
    task automatic reset_mid_frame();
        logic [24:0] data;
        data = rand_valid();
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            sdi = data[23-i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_val("midrst_ready", 32'(ready), 32'd0);
        check_val("midrst_sdo",   32'(sdo),   32'd0);
        check_output("midrst");
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sdi = 1'($urandom);
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        check_val("midrst_idle_sdo", 32'(sdo), 32'd0);
        cs  = 1'b1;
        sdi = 1'b0;
        repeat (12) @(negedge clk);
        check_output("midrst_after");
    endtask

    initial begin
        int nb;
        int n;
        int rc0;
        exp_t f;

        reset = 1'b0;
        cs    = 1'b1;
        sck   = 1'b0;
        sdi   = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_sdo",   32'(sdo),   32'd0);
        check_output("rst");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Known-good command: brush 1, color 1, x 160, y 5.
        apply_stimulus({1'b0, 1'b1, 3'd1, 10'd160, 10'd5}, 24, 4, 1'b1);
        check_val("first_brush", 32'(brush),    32'd1);
        check_val("first_color", 32'(newColor), 32'd1);
        check_val("first_x",     32'(x),        32'd160);
        check_val("first_y",     32'(y),        32'd5);

        // x on the boundary must be rejected and leave outputs alone.
        apply_stimulus({1'b0, 1'b0, 3'd2, 10'd640, 10'd0}, 24, 4, 1'b1);
        check_val("oob_hold_x", 32'(x), 32'd160);

        // y on the boundary, then the last legal corner.
        apply_stimulus({1'b0, 1'b1, 3'd7, 10'd0, 10'd480}, 24, 4, 1'b1);
        apply_stimulus({1'b0, 1'b1, 3'd7, 10'd639, 10'd479}, 24, 4, 1'b1);
        apply_stimulus(rand_valid(), 24, 4, 1'b1);

        // Three accepted and two rejected so far; reset to the 3/1 case.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        repeat (3) apply_stimulus(rand_valid(), 24, 4, 1'b1);
        apply_stimulus({1'b0, 1'b0, 3'd0, 10'd700, 10'd3}, 24, 4, 1'b1);
        apply_stimulus(rand_valid(), 24, 4, 1'b1);
        check_val("status_3_1", 32'(last_cap[24:1]), 32'h030100);

        // Short then long frame: both rejected.
        apply_stimulus(rand_valid(), 23, 4, 1'b1);
        apply_stimulus({1'b1, rand_valid()} ^ 25'(1), 25, 4, 1'b1);
        apply_stimulus(rand_valid(), 24, 4, 1'b1);
        check_val("status_short_long", 32'(last_cap[16:9]), 32'd3);

        // One-cycle cs glitch must not start (and reject) a frame.
        cs = 1'b0;
        @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        apply_stimulus(rand_valid(), 24, 4, 1'b1);

        // Random mix of lengths and coordinates around the boundaries.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(4, 0))
                0:       nb = 23;
                4:       nb = 25;
                default: nb = 24;
            endcase
            f.brush = 1'($urandom);
            f.color = 3'($urandom);
            f.x     = 10'($urandom_range(700, 0));
            f.y     = 10'($urandom_range(520, 0));
            apply_stimulus({1'($urandom), f}, nb, 4, 1'b1);
        end

        // Reset mid-frame, then exactly one ready for a fresh valid frame.
        reset_mid_frame();
        rc0 = ready_count;
        apply_stimulus(rand_valid(), 24, 4, 1'b1);
        check_val("post_reset_status", 32'(last_cap[24:1]), 32'h000000);
        check_val("post_reset_readies", 32'(ready_count - rc0), 32'd1);

        // Accepted counter wrap: run it round to zero at clk/4.
        n = 256 - int'(m_acc);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(rand_valid(), 24, 2, 1'b0);
        end
        apply_stimulus(rand_valid(), 24, 4, 1'b1);
        check_val("wrap_acc", 32'(last_cap[24:17]), 32'd0);

        repeat (10) @(negedge clk);
        check_val("ready_total", 32'(ready_count), 32'(exp_ready_count));
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
